// File: rtl/pcileech_tlps128_cpld_tx.sv
// ============================================================================
// pcileech_tlps128_cpld_tx
//
// Purpose:
//   Completion transmitter for BAR read requests. It accepts one completion
//   context at a time and a stream of 32-bit read-data DWs from the BAR
//   implementation, and emits one 128-bit CplD (with data) or Cpl (no data)
//   TLP towards one source port of the TX TLP mux.
//   The header is three DWs, so the first beat carries the header plus the
//   first data DW. Each later beat carries up to four data DWs.
//   If read data stalls in the first beat, the completion becomes a
//   Completer Abort with no data. If it stalls later, the rest of the
//   payload is padded with 0xFFFFFFFF so the TLP still finishes cleanly.
//
// Ports:
//   clk_pcie          PCIe user clock
//   rst               asynchronous reset, active high
//   pcie_id           completer ID (bus/dev/fn), latched with the context
//   ctx_*             completion context with valid/ready handshake
//   dat_*             read-data DW stream with valid/ready handshake
//   tlps_*            128-bit TLP beat stream, DW0 in [31:0]
//   stat_cpl_count    completions sent, wraps at 16 bits
//   stat_timeout      sticky flag, set when a data timeout has occurred
// ============================================================================
module pcileech_tlps128_cpld_tx #(
    parameter int PARAM_MAX_DW       = 16,   // max payload DWs per completion (1..63)
    parameter int PARAM_DATA_TIMEOUT = 1024  // cycles allowed between data DWs
) (
    input  logic         clk_pcie,
    input  logic         rst,
    input  logic [15:0]  pcie_id,
    // completion context
    input  logic         ctx_valid,
    output logic         ctx_ready,
    input  logic [15:0]  ctx_req_id,
    input  logic [7:0]   ctx_tag,
    input  logic [6:0]   ctx_lower_addr,
    input  logic [5:0]   ctx_len_dw,
    input  logic [11:0]  ctx_byte_count,
    input  logic [2:0]   ctx_status,
    // read data
    input  logic         dat_valid,
    output logic         dat_ready,
    input  logic [31:0]  dat_data,
    // TLP output
    output logic [127:0] tlps_tdata,
    output logic [3:0]   tlps_tkeepdw,
    output logic         tlps_tfirst,
    output logic         tlps_tlast,
    output logic         tlps_tvalid,
    input  logic         tlps_tready,
    // statistics
    output logic [15:0]  stat_cpl_count,
    output logic         stat_timeout
);

    localparam logic [2:0] ST_SC = 3'b000;
    localparam logic [2:0] ST_CA = 3'b100;

    localparam int TO_W = $clog2(PARAM_DATA_TIMEOUT + 1);
    // Counter value on the last allowed waiting cycle; the timeout fires
    // on the PARAM_DATA_TIMEOUT-th consecutive cycle without data.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(PARAM_DATA_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_DATA,
        S_NODATA
    } state_t;

    // Builds the three header DWs as {DW2, DW1, DW0}.
    function automatic logic [95:0] f_hdr(
        input logic [15:0] cpl_id,
        input logic [15:0] req_id,
        input logic [7:0]  tag,
        input logic [6:0]  lower_addr,
        input logic [5:0]  len_dw,
        input logic [11:0] byte_count,
        input logic [2:0]  status,
        input logic        with_data
    );
        logic [31:0] dw0;
        dw0 = with_data ? (32'h4A00_0000 | {26'd0, len_dw}) : 32'h0A00_0000;
        return {req_id, tag, 1'b0, lower_addr,
                cpl_id, status, 1'b0, byte_count,
                dw0};
    endfunction

    // DW-valid mask for a beat whose highest filled lane is `lane`.
    function automatic logic [3:0] f_keep(input logic [1:0] lane);
        logic [3:0] keep;
        case (lane)
            2'd0:    keep = 4'b0001;
            2'd1:    keep = 4'b0011;
            2'd2:    keep = 4'b0111;
            default: keep = 4'b1111;
        endcase
        return keep;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [15:0]     r_pcie_id;
    logic [15:0]     r_req_id;
    logic [7:0]      r_tag;
    logic [6:0]      r_lower_addr;
    logic [5:0]      r_len;
    logic [11:0]     r_byte_count;
    logic [2:0]      r_status;
    logic [5:0]      r_remaining;   // payload DWs not yet taken
    logic [1:0]      r_lane;        // next lane to fill in a DATA beat
    logic            r_fill;        // DATA-phase timeout: pad with ones
    logic [TO_W-1:0] r_to_cnt;

    logic [127:0]    r_tdata;
    logic [3:0]      r_tkeepdw;
    logic            r_tfirst;
    logic            r_tlast;
    logic            r_tvalid;
    logic            r_ctx_ready;
    logic            r_dat_ready;
    logic [15:0]     r_cpl_count;
    logic            r_stat_timeout;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_ctx_fire;
    logic        w_ctx_nodata;
    logic [2:0]  w_ctx_status;
    logic        w_dat_fire;
    logic        w_take;
    logic [31:0] w_dw;
    logic        w_accept;

    assign w_ctx_fire   = ctx_valid & r_ctx_ready;
    // Non-SC statuses never carry data; an SC with an unusable length is
    // turned into a Completer Abort.
    assign w_ctx_nodata = (ctx_status != ST_SC) || (ctx_len_dw == 6'd0) ||
                          ({26'd0, ctx_len_dw} > 32'(PARAM_MAX_DW));
    assign w_ctx_status = (ctx_status == ST_SC && w_ctx_nodata) ? ST_CA : ctx_status;

    assign w_dat_fire   = dat_valid & r_dat_ready;
    // After a DATA-phase timeout one padding DW is "taken" per cycle.
    assign w_take       = w_dat_fire | (r_fill & (r_state == S_DATA) & ~r_tvalid);
    assign w_dw         = r_fill ? 32'hFFFF_FFFF : dat_data;
    assign w_accept     = r_tvalid & tlps_tready;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: every register here is assigned with <= so all updates in this
    // block see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            // NOTE: the latched context fields are reset too; they are few,
            // and it keeps the header deterministic right after reset.
            r_state        <= S_IDLE;
            r_pcie_id      <= '0;
            r_req_id       <= '0;
            r_tag          <= '0;
            r_lower_addr   <= '0;
            r_len          <= '0;
            r_byte_count   <= '0;
            r_status       <= '0;
            r_remaining    <= '0;
            r_lane         <= '0;
            r_fill         <= 1'b0;
            r_to_cnt       <= '0;
            r_tdata        <= '0;
            r_tkeepdw      <= '0;
            r_tfirst       <= 1'b0;
            r_tlast        <= 1'b0;
            r_tvalid       <= 1'b0;
            r_ctx_ready    <= 1'b1;
            r_dat_ready    <= 1'b0;
            r_cpl_count    <= '0;
            r_stat_timeout <= 1'b0;
        end else begin
            case (r_state)
                // ------------------------------------------------------
                S_IDLE: begin
                    if (w_ctx_fire) begin
                        r_pcie_id    <= pcie_id;
                        r_req_id     <= ctx_req_id;
                        r_tag        <= ctx_tag;
                        r_lower_addr <= ctx_lower_addr;
                        r_len        <= ctx_len_dw;
                        r_byte_count <= ctx_byte_count;
                        r_status     <= w_ctx_status;
                        r_remaining  <= ctx_len_dw;
                        r_to_cnt     <= '0;
                        r_fill       <= 1'b0;
                        r_ctx_ready  <= 1'b0;
                        if (w_ctx_nodata) begin
                            // Header-only beat can be built straight from the inputs.
                            r_tdata   <= {32'd0, f_hdr(pcie_id, ctx_req_id, ctx_tag,
                                                       ctx_lower_addr, ctx_len_dw,
                                                       ctx_byte_count, w_ctx_status, 1'b0)};
                            r_tkeepdw <= 4'b0111;
                            r_tfirst  <= 1'b1;
                            r_tlast   <= 1'b1;
                            r_tvalid  <= 1'b1;
                            r_state   <= S_NODATA;
                        end else begin
                            r_dat_ready <= 1'b1;
                            r_state     <= S_FIRST;
                        end
                    end
                end

                // ------------------------------------------------------
                S_NODATA: begin
                    if (w_accept) begin
                        r_tvalid    <= 1'b0;
                        r_cpl_count <= r_cpl_count + 16'd1;
                        r_ctx_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                // ------------------------------------------------------
                S_FIRST: begin
                    if (!r_tvalid) begin
                        if (w_dat_fire) begin
                            r_tdata     <= {dat_data, f_hdr(r_pcie_id, r_req_id, r_tag,
                                                            r_lower_addr, r_len,
                                                            r_byte_count, r_status, 1'b1)};
                            r_tkeepdw   <= 4'b1111;
                            r_tfirst    <= 1'b1;
                            r_tlast     <= (r_len == 6'd1);
                            r_tvalid    <= 1'b1;
                            r_dat_ready <= 1'b0;
                            r_remaining <= r_remaining - 6'd1;
                            r_to_cnt    <= '0;
                        end else if (r_to_cnt == TO_LAST) begin
                            // No data at all: give up and send a CA without payload.
                            r_tdata        <= {32'd0, f_hdr(r_pcie_id, r_req_id, r_tag,
                                                            r_lower_addr, r_len,
                                                            r_byte_count, ST_CA, 1'b0)};
                            r_tkeepdw      <= 4'b0111;
                            r_tfirst       <= 1'b1;
                            r_tlast        <= 1'b1;
                            r_tvalid       <= 1'b1;
                            r_dat_ready    <= 1'b0;
                            r_status       <= ST_CA;
                            r_stat_timeout <= 1'b1;
                            r_state        <= S_NODATA;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end else if (w_accept) begin
                        r_tvalid <= 1'b0;
                        if (r_tlast) begin
                            r_cpl_count <= r_cpl_count + 16'd1;
                            r_ctx_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            // Unused lanes of a short DATA beat must read as zero.
                            r_tdata     <= '0;
                            r_tfirst    <= 1'b0;
                            r_lane      <= 2'd0;
                            r_to_cnt    <= '0;
                            r_dat_ready <= 1'b1;
                            r_state     <= S_DATA;
                        end
                    end
                end

                // ------------------------------------------------------
                S_DATA: begin
                    if (!r_tvalid) begin
                        if (w_take) begin
                            r_tdata[{r_lane, 5'd0} +: 32] <= w_dw;
                            r_remaining <= r_remaining - 6'd1;
                            r_to_cnt    <= '0;
                            if (r_remaining == 6'd1 || r_lane == 2'd3) begin
                                r_tkeepdw   <= f_keep(r_lane);
                                r_tlast     <= (r_remaining == 6'd1);
                                r_tvalid    <= 1'b1;
                                r_dat_ready <= 1'b0;
                            end else begin
                                r_lane <= r_lane + 2'd1;
                            end
                        end else if (r_to_cnt == TO_LAST) begin
                            // Data stalled mid-TLP: pad the rest instead of aborting.
                            r_fill         <= 1'b1;
                            r_dat_ready    <= 1'b0;
                            r_stat_timeout <= 1'b1;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end else if (w_accept) begin
                        r_tvalid <= 1'b0;
                        if (r_tlast) begin
                            r_cpl_count <= r_cpl_count + 16'd1;
                            r_ctx_ready <= 1'b1;
                            r_fill      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_tdata     <= '0;
                            r_lane      <= 2'd0;
                            r_to_cnt    <= '0;
                            r_dat_ready <= ~r_fill;
                        end
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_tvalid    <= 1'b0;
                    r_ctx_ready <= 1'b1;
                    r_dat_ready <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ctx_ready      = r_ctx_ready;
    assign dat_ready      = r_dat_ready;
    assign tlps_tdata     = r_tdata;
    assign tlps_tkeepdw   = r_tkeepdw;
    assign tlps_tfirst    = r_tfirst;
    assign tlps_tlast     = r_tlast;
    assign tlps_tvalid    = r_tvalid;
    assign stat_cpl_count = r_cpl_count;
    assign stat_timeout   = r_stat_timeout;

endmodule
